ber_sync_ctrl: RTL and testbench

BER_SYNC_CTRL -- requirements
Module: ber_sync_ctrl

---
 rtl/ber_pkg.sv | 24 ++
 rtl/ber_delay_line.sv | 37 +++
 rtl/ber_sync_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ber_sync_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// ber_pkg
//   Shared definitions for the BER sync controller: default parameter values,
//   the statistics counter width, the controller state encoding and a helper
//   for index widths.
package ber_pkg;

  localparam int DEF_DELAY_LEN = 1024;  // candidate PRBS-to-RX latencies
  localparam int DEF_WINDOW    = 511;   // samples per evaluation window
  localparam int DEF_LOSS_THR  = 32;    // window errors that drop lock
  localparam int COUNT_W       = 32;    // locked bit/error counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SCAN = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  // Width of an index covering 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ber_delay_line.sv
// ber_delay_line
//   Reference-bit history with a selectable tap.
//   clock   : rising-edge clock
//   i_reset : asynchronous active-high reset, clears the whole history
//   i_shift : shift i_bit into position 0 (older bits move up)
//   i_bit   : reference bit to record
//   i_sel   : tap index; index d is the bit recorded d+1 shifts ago
//   o_tap   : history[i_sel], read before the pending shift
module ber_delay_line
  import ber_pkg::*;
#(
  parameter int  DELAY_LEN = DEF_DELAY_LEN,
  localparam int SEL_W     = idx_width(DELAY_LEN)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_tap
);

  logic [DELAY_LEN-1:0] history;

  // Plain register chain: the whole history must clear on reset, which rules
  // out a RAM-based implementation.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      history <= '0;
    end else if (i_shift) begin
      history <= {history[DELAY_LEN-2:0], i_bit};
    end
  end

  assign o_tap = history[i_sel];

endmodule

// File: rtl/ber_sync_ctrl.sv
// ber_sync_ctrl
//   Searches the PRBS-to-RX latency window by window, locks on an error-free
//   window and then accumulates bit/error statistics until a window reaches
//   the loss threshold, at which point the search resumes at the next delay.
//   clock         : rising-edge clock
//   i_reset       : asynchronous active-high reset
//   i_enable      : global run enable; low freezes everything
//   i_valid       : sample strobe (accepted when i_enable is also high)
//   i_ref_bit     : local PRBS reference bit
//   i_rx_bit      : received decision bit
//   o_locked      : high while locked
//   o_delay       : candidate / locked latency index
//   o_window_done : one-cycle pulse after each closed window
//   o_bit_count   : samples compared while locked (saturating)
//   o_err_count   : errors seen while locked (saturating)
module ber_sync_ctrl
  import ber_pkg::*;
#(
  parameter int  DELAY_LEN = DEF_DELAY_LEN,
  parameter int  WINDOW    = DEF_WINDOW,
  parameter int  LOSS_THR  = DEF_LOSS_THR,
  localparam int DELAY_W   = idx_width(DELAY_LEN),
  localparam int WIN_W     = idx_width(WINDOW),
  localparam int ACC_W     = $clog2(WINDOW + 1)
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic               i_ref_bit,
  input  logic               i_rx_bit,
  output logic               o_locked,
  output logic [DELAY_W-1:0] o_delay,
  output logic               o_window_done,
  output logic [COUNT_W-1:0] o_bit_count,
  output logic [COUNT_W-1:0] o_err_count
);

  state_t               state, state_next;
  logic [DELAY_W-1:0]   fill_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [ACC_W-1:0]     win_acc;
  logic [ACC_W-1:0]     win_errs;
  logic [DELAY_W-1:0]   delay;
  logic                 window_done;
  logic [COUNT_W-1:0]   bit_count;
  logic [COUNT_W-1:0]   err_count;
  logic                 accept;
  logic                 tap;
  logic                 err_bit;
  logic                 in_window;
  logic                 win_close;
  logic                 step_delay;
  logic                 clear_counts;

  assign accept    = i_enable & i_valid;
  assign err_bit   = i_rx_bit ^ tap;
  assign in_window = (state == ST_SCAN) || (state == ST_LOCK);
  assign win_close = accept && in_window && (win_cnt == WIN_W'(WINDOW - 1));
  // Window total including the current sample, used for the close decision.
  assign win_errs  = win_acc + ACC_W'(err_bit);

  // The tap is read with the current delay before this sample is shifted in.
  ber_delay_line #(
    .DELAY_LEN (DELAY_LEN)
  ) u_delay_line (
    .clock   (clock),
    .i_reset (i_reset),
    .i_shift (accept),
    .i_bit   (i_ref_bit),
    .i_sel   (delay),
    .o_tap   (tap)
  );

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    step_delay   = 1'b0;
    clear_counts = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        // fill_cnt already includes the sample taken in IDLE.
        if (accept && (fill_cnt == DELAY_W'(DELAY_LEN - 1))) begin
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (win_close) begin
          if (win_errs == '0) begin
            state_next   = ST_LOCK;
            clear_counts = 1'b1;
          end else begin
            step_delay = 1'b1;
          end
        end
      end
      ST_LOCK: begin
        if (win_close && (int'(win_errs) >= LOSS_THR)) begin
          state_next = ST_SCAN;
          step_delay = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      fill_cnt    <= '0;
      win_cnt     <= '0;
      win_acc     <= '0;
      delay       <= '0;
      window_done <= 1'b0;
      bit_count   <= '0;
      err_count   <= '0;
    end else begin
      window_done <= win_close;

      if (accept && (state == ST_IDLE)) begin
        fill_cnt <= DELAY_W'(1);
      end else if (accept && (state == ST_FILL)) begin
        fill_cnt <= (state_next == ST_SCAN) ? '0 : fill_cnt + DELAY_W'(1);
      end

      if (accept && in_window) begin
        if (win_close) begin
          win_cnt <= '0;
          win_acc <= '0;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          win_acc <= win_errs;
        end
      end

      if (step_delay) begin
        delay <= (delay == DELAY_W'(DELAY_LEN - 1)) ? '0 : delay + DELAY_W'(1);
      end

      // The sample that closes a losing window is still a locked sample.
      if (clear_counts) begin
        bit_count <= '0;
        err_count <= '0;
      end else if (accept && (state == ST_LOCK)) begin
        if (bit_count != '1) begin
          bit_count <= bit_count + COUNT_W'(1);
        end
        if (err_bit && (err_count != '1)) begin
          err_count <= err_count + COUNT_W'(1);
        end
      end
    end
  end

  assign o_locked      = (state == ST_LOCK);
  assign o_delay       = delay;
  assign o_window_done = window_done;
  assign o_bit_count   = bit_count;
  assign o_err_count   = err_count;

endmodule

// File: tb/tb_ber_sync_ctrl.sv
// tb_ber_sync_ctrl
//   Two controller instances: inst0 with default parameters for the nominal
//   scenarios, inst1 small (DELAY_LEN 16, WINDOW 15, LOSS_THR 4) for delay wrap
//   and a randomized run. Stimulus feeds a sample-level reference model that
//   pushes one expectation per closed window; a monitor pops on o_window_done.
module tb_ber_sync_ctrl;
  import ber_pkg::*;

  localparam int DL0 = 1024, W0 = 511, T0 = 32;
  localparam int DL1 = 16,   W1 = 15,  T1 = 4;
  localparam int HB  = 8192;                 // bench history buffer depth
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;
  logic en_s  [2];
  logic val_s [2];
  logic ref_s [2];
  logic rx_s  [2];

  logic        locked0, done0, locked1, done1;
  logic [9:0]  delay0;
  logic [3:0]  delay1;
  logic [31:0] bits0, errs0, bits1, errs1;

  always #5 clock = ~clock;

  ber_sync_ctrl #(.DELAY_LEN(DL0), .WINDOW(W0), .LOSS_THR(T0)) u_dut0 (
    .clock(clock), .i_reset(i_reset), .i_enable(en_s[0]), .i_valid(val_s[0]),
    .i_ref_bit(ref_s[0]), .i_rx_bit(rx_s[0]), .o_locked(locked0),
    .o_delay(delay0), .o_window_done(done0), .o_bit_count(bits0),
    .o_err_count(errs0)
  );

  ber_sync_ctrl #(.DELAY_LEN(DL1), .WINDOW(W1), .LOSS_THR(T1)) u_dut1 (
    .clock(clock), .i_reset(i_reset), .i_enable(en_s[1]), .i_valid(val_s[1]),
    .i_ref_bit(ref_s[1]), .i_rx_bit(rx_s[1]), .o_locked(locked1),
    .o_delay(delay1), .o_window_done(done1), .o_bit_count(bits1),
    .o_err_count(errs1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit     locked;
    int     delay;
    longint bits;
    longint errs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int     m_dl [2] = '{DL0, DL1};
  int     m_w  [2] = '{W0, W1};
  int     m_t  [2] = '{T0, T1};
  bit     m_ref [2][HB];   // reference bit of every accepted sample, by index
  longint m_n   [2];       // accepted samples since reset
  bit     m_locked [2];
  int     m_delay  [2];
  int     m_widx   [2];
  int     m_werr   [2];
  longint m_bits   [2];
  longint m_errs   [2];

  // stimulus-side record of reference bits, used to build the delayed rx
  bit     s_hist [2][HB];
  longint s_n    [2];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_locked[i] = 0; m_delay[i] = 0; m_widx[i] = 0;
      m_werr[i] = 0; m_bits[i] = 0; m_errs[i] = 0; s_n[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One accepted sample: compare rx against the reference bit sent
  // (delay+1) samples earlier; samples before the first one read as 0.
  task automatic model_step(input int i, input bit r, input bit x);
    longint k;
    bit     tapv, e;
    exp_t   ex;
    k    = m_n[i] - 1 - m_delay[i];
    tapv = (k < 0) ? 1'b0 : m_ref[i][int'(k % HB)];
    e    = x ^ tapv;
    m_ref[i][int'(m_n[i] % HB)] = r;
    m_n[i]++;
    if (m_n[i] <= m_dl[i]) return;           // history still filling
    if (m_locked[i]) begin
      if (m_bits[i] < CMAX) m_bits[i]++;
      if (e && m_errs[i] < CMAX) m_errs[i]++;
    end
    m_widx[i]++;
    m_werr[i] += int'(e);
    if (m_widx[i] == m_w[i]) begin
      if (!m_locked[i]) begin
        if (m_werr[i] == 0) begin
          m_locked[i] = 1; m_bits[i] = 0; m_errs[i] = 0;
        end else begin
          m_delay[i] = (m_delay[i] + 1) % m_dl[i];
        end
      end else if (m_werr[i] >= m_t[i]) begin
        m_locked[i] = 0;
        m_delay[i]  = (m_delay[i] + 1) % m_dl[i];
      end
      ex.locked = m_locked[i]; ex.delay = m_delay[i];
      ex.bits   = m_bits[i];   ex.errs  = m_errs[i];
      if (i == 0) q0.push_back(ex); else q1.push_back(ex);
      m_widx[i] = 0;
      m_werr[i] = 0;
    end
  endtask

  // ---------------- checking ----------------
  function automatic longint dut_get(input int i, input int f);
    case (f)
      0: return (i == 0) ? longint'(locked0) : longint'(locked1);
      1: return (i == 0) ? longint'(delay0)  : longint'(delay1);
      2: return (i == 0) ? longint'(done0)   : longint'(done1);
      3: return (i == 0) ? longint'(bits0)   : longint'(bits1);
      default: return (i == 0) ? longint'(errs0) : longint'(errs1);
    endcase
  endfunction

  task automatic check(input string name, input int i, input longint got,
                       input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, i, got, exp);
    end
  endtask

  task automatic check_zero(input int i);
    check("rst_locked", i, dut_get(i, 0), 0);
    check("rst_delay",  i, dut_get(i, 1), 0);
    check("rst_done",   i, dut_get(i, 2), 0);
    check("rst_bits",   i, dut_get(i, 3), 0);
    check("rst_errs",   i, dut_get(i, 4), 0);
  endtask

  task automatic check_now(input string name, input int i);
    check({name, "_locked"}, i, dut_get(i, 0), longint'(m_locked[i]));
    check({name, "_delay"},  i, dut_get(i, 1), longint'(m_delay[i]));
    check({name, "_bits"},   i, dut_get(i, 3), m_bits[i]);
    check({name, "_errs"},   i, dut_get(i, 4), m_errs[i]);
  endtask

  task automatic mon_pop(input int i);
    exp_t ex;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    n_vec++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL spurious_window_done inst%0d: got pulse expected none", i);
      return;
    end
    ex = (i == 0) ? q0.pop_front() : q1.pop_front();
    $display("window inst%0d: locked=%0d delay=%0d bits=%0d errs=%0d", i,
             dut_get(i, 0), dut_get(i, 1), dut_get(i, 3), dut_get(i, 4));
    check("win_locked", i, dut_get(i, 0), longint'(ex.locked));
    check("win_delay",  i, dut_get(i, 1), longint'(ex.delay));
    check("win_bits",   i, dut_get(i, 3), ex.bits);
    check("win_errs",   i, dut_get(i, 4), ex.errs);
  endtask

  always @(negedge clock) begin
    if (!i_reset) begin
      if (done0) mon_pop(0);
      if (done1) mon_pop(1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input bit e, input bit v, input bit r,
                       input bit x);
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b0; val_s[k] = 1'b0; ref_s[k] = 1'b0; rx_s[k] = 1'b0;
    end
    en_s[i] = e; val_s[i] = v; ref_s[i] = r; rx_s[i] = x;
    if (e && v) model_step(i, r, x);
    @(posedge clock);
    #1;
  endtask

  // rx = reference delayed by d samples, optionally corrupted:
  // inv_every aligns inversions to window positions, inv_pct is random,
  // all_inv inverts everything; ref0 forces reference bits to zero.
  task automatic sample_ev(input int i, input int d, input int inv_every,
                           input int inv_pct, input bit all_inv,
                           input bit ref0, input bit e, input bit v);
    bit     r, x;
    longint k;
    r = ref0 ? 1'b0 : 1'($urandom);
    k = s_n[i] - d;
    x = (k < 0) ? 1'b0 : s_hist[i][int'(k % HB)];
    if (all_inv) x = ~x;
    else if (inv_every > 0 && (m_widx[i] % inv_every) == inv_every - 1) x = ~x;
    else if (inv_pct > 0 && $urandom_range(0, 99) < inv_pct) x = ~x;
    if (e && v) begin
      s_hist[i][int'(s_n[i] % HB)] = r;
      s_n[i]++;
    end
    drive(i, e, v, r, x);
  endtask

  task automatic sample(input int i, input int d, input int inv_every);
    sample_ev(i, d, inv_every, 0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b0; val_s[k] = 1'b0; ref_s[k] = 1'b0; rx_s[k] = 1'b0;
    end
    i_reset = 1'b1;
    model_reset();
    #1;
    check_zero(0);
    check_zero(1);
    @(posedge clock);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic run_to_lock(input int i, input int d, input int limit);
    for (int c = 0; c < limit && !m_locked[i]; c++) sample(i, d, 0);
    drive(i, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      en_s[k] = 1'b0; val_s[k] = 1'b0; ref_s[k] = 1'b0; rx_s[k] = 1'b0;
    end
    do_reset();

    // Nominal acquisition: true latency 6 samples -> lock at delay 5.
    run_to_lock(0, 6, DL0 + 20 * W0);
    check("acq_locked", 0, longint'(locked0), 1);
    check("acq_delay",  0, longint'(delay0), 5);
    check("acq_errs",   0, longint'(errs0), 0);

    // Every 16th bit inverted: 31 errors per window, lock held.
    for (int c = 0; c < W0; c++) sample(0, 6, 16);
    drive(0, 0, 0, 0, 0);
    check("inv16_locked", 0, longint'(locked0), 1);
    check("inv16_bits",   0, longint'(bits0), 511);
    check("inv16_errs",   0, longint'(errs0), 31);
    for (int c = 0; c < W0; c++) sample(0, 6, 16);
    drive(0, 0, 0, 0, 0);
    check("inv16b_bits", 0, longint'(bits0), 1022);
    check("inv16b_errs", 0, longint'(errs0), 62);

    // Every 8th bit inverted: 63 errors -> back to SCAN at delay 6.
    for (int c = 0; c < W0; c++) sample(0, 6, 8);
    drive(0, 0, 0, 0, 0);
    check("inv8_locked", 0, longint'(locked0), 0);
    check("inv8_delay",  0, longint'(delay0), 6);
    check("inv8_bits",   0, longint'(bits0), 1533);
    check("inv8_errs",   0, longint'(errs0), 125);
    for (int c = 0; c < 50; c++) sample(0, 6, 0);
    drive(0, 0, 0, 0, 0);
    check_now("scan_hold", 0);

    // Half-rate valid with a 100-cycle enable-low gap mid-window.
    do_reset();
    for (int c = 0; c < 2 * (DL0 + 20 * W0) && !m_locked[0]; c++) begin
      sample(0, 6, 0);
      drive(0, 1, 0, 1'($urandom), 1'($urandom));
      if (c == DL0 + W0 + 200) begin
        for (int g = 0; g < 100; g++)
          drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
        check_now("en_low_hold", 0);
      end
    end
    drive(0, 0, 0, 0, 0);
    check("half_locked", 0, longint'(locked0), 1);
    check("half_delay",  0, longint'(delay0), 5);

    // Reset pulse in LOCK, then a full re-acquisition.
    for (int c = 0; c < 100; c++) sample(0, 6, 0);
    check_now("pre_reset", 0);
    do_reset();
    run_to_lock(0, 6, DL0 + 20 * W0);
    check("reacq_locked", 0, longint'(locked0), 1);
    check("reacq_delay",  0, longint'(delay0), 5);

    // Small instance: true tap DL-2 locks there; forced failures wrap to 0.
    run_to_lock(1, DL1 - 1, DL1 + 40 * W1);
    check("tap14_locked", 1, longint'(locked1), 1);
    check("tap14_delay",  1, longint'(delay1), DL1 - 2);
    for (int c = 0; c < W1; c++) sample_ev(1, DL1 - 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1, 0, 0, 0, 0);
    check("fail14_delay", 1, longint'(delay1), DL1 - 1);
    for (int c = 0; c < W1; c++) sample_ev(1, DL1 - 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1, 0, 0, 0, 0);
    check("wrap_delay",  1, longint'(delay1), 0);
    check("wrap_locked", 1, longint'(locked1), 0);

    // Randomized segments on the small instance.
    for (int seg = 0; seg < 16; seg++) begin
      int d, pct;
      if (seg == 8) do_reset();
      d   = $urandom_range(1, DL1);
      pct = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 40) : 0;
      for (int c = 0; c < 200; c++)
        sample_ev(1, d, 0, pct, 1'b0, 1'b0,
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7));
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_now("rand_final", 1);

    check("pending_windows0", 0, longint'(q0.size()), 0);
    check("pending_windows1", 1, longint'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
